// File: rtl/capture_pkg.sv
// Shared types and trigger-match helper for the capture controller.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Widest channel word the match helper accepts; callers zero-extend.
    localparam int MAX_WIDTH = 64;

    // Level match on masked bits; edge bits additionally need the previous
    // sample to differ from the value (a transition into the value).
    function automatic logic trig_match(
        input logic [MAX_WIDTH-1:0] data,
        input logic [MAX_WIDTH-1:0] value,
        input logic [MAX_WIDTH-1:0] mask,
        input logic [MAX_WIDTH-1:0] edge_bits,
        input logic [MAX_WIDTH-1:0] prev,
        input logic                 prev_valid
    );
        logic [MAX_WIDTH-1:0] edge_req;
        logic                 level_ok;
        logic                 edge_ok;
        edge_req = mask & edge_bits;
        level_ok = (((data ^ value) & mask) == {MAX_WIDTH{1'b0}});
        if (edge_req == {MAX_WIDTH{1'b0}}) begin
            edge_ok = 1'b1;
        end else begin
            edge_ok = prev_valid && (((prev ^ value) & edge_req) == edge_req);
        end
        return level_ok & edge_ok;
    endfunction

endpackage

// File: rtl/capture_ctrl_strobe_sync.sv
// Two-flop synchronizer for the delayed sample strobe and channel word,
// followed by rising-edge detection of the synchronized strobe.
module strobe_sync #(
    parameter int WIDTH = 8
) (
    input  logic             rdclk,
    input  logic             nreset,
    input  logic             strobe,
    input  logic [WIDTH-1:0] din,
    output logic             sample_ev,
    output logic [WIDTH-1:0] sample_data
);

    logic             strobe_meta;
    logic             strobe_s;
    logic             strobe_q;
    logic [WIDTH-1:0] din_meta;
    logic [WIDTH-1:0] din_s;

    // Synchronizer stages and edge register; the edge register runs in every state.
    always_ff @(posedge rdclk) begin
        if (!nreset) begin
            strobe_meta <= 1'b0;
            strobe_s    <= 1'b0;
            strobe_q    <= 1'b0;
            din_meta    <= {WIDTH{1'b0}};
            din_s       <= {WIDTH{1'b0}};
        end else begin
            strobe_meta <= strobe;
            strobe_s    <= strobe_meta;
            strobe_q    <= strobe_s;
            din_meta    <= din;
            din_s       <= din_meta;
        end
    end

    assign sample_ev   = strobe_s & ~strobe_q;
    assign sample_data = din_s;

endmodule

// File: rtl/capture_ctrl.sv
// Logic-analyzer capture controller: circular pre/post-trigger capture into RAM.
// Optional edge-qualified triggering is enabled by defining CAPTURE_EDGE_TRIG_EN.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             rdclk,
    input  logic             nreset,
    input  logic             start,
    input  logic             abort,
    input  logic             strobe,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
`ifdef CAPTURE_EDGE_TRIG_EN
    input  logic [WIDTH-1:0] trig_edge,
`endif
    input  logic [AW-1:0]    pre_cnt,
    input  logic [AW-1:0]    post_cnt,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    trig_addr
);

    logic             sample_ev;
    logic [WIDTH-1:0] sample_data;

    strobe_sync #(.WIDTH(WIDTH)) u_sync (
        .rdclk       (rdclk),
        .nreset      (nreset),
        .strobe      (strobe),
        .din         (din),
        .sample_ev   (sample_ev),
        .sample_data (sample_data)
    );

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_next;
    logic [AW-1:0]    fill;
    logic [AW-1:0]    fill_next;
    logic [AW-1:0]    post;
    logic [AW-1:0]    post_next;
    logic [AW-1:0]    trig_addr_next;
    logic             wr_en_next;
    logic [AW-1:0]    wr_addr_next;
    logic [WIDTH-1:0] wr_data_next;
    logic             busy_next;
    logic             done_next;
    logic             match;
    logic             write;
    logic [AW-1:0]    fill_inc;
    logic [AW-1:0]    post_inc;

`ifdef CAPTURE_EDGE_TRIG_EN
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_next;
    logic             prev_valid;
    logic             prev_valid_next;

    assign match = trig_match(MAX_WIDTH'(sample_data), MAX_WIDTH'(trig_value),
                              MAX_WIDTH'(trig_mask), MAX_WIDTH'(trig_edge),
                              MAX_WIDTH'(prev), prev_valid);
`else
    assign match = trig_match(MAX_WIDTH'(sample_data), MAX_WIDTH'(trig_value),
                              MAX_WIDTH'(trig_mask), {MAX_WIDTH{1'b0}},
                              {MAX_WIDTH{1'b0}}, 1'b1);
`endif

    assign fill_inc = fill + AW'(1);
    assign post_inc = post + AW'(1);

    // Next-state, pointer/counter and output decode; abort beats start beats sample.
    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        fill_next      = fill;
        post_next      = post;
        trig_addr_next = trig_addr;
        wr_addr_next   = wr_addr;
        wr_data_next   = wr_data;
        write          = 1'b0;
`ifdef CAPTURE_EDGE_TRIG_EN
        prev_next       = prev;
        prev_valid_next = prev_valid;
`endif
        if (abort) begin
            state_next = IDLE;
        end else if (start && ((state == IDLE) || (state == DONE))) begin
            ptr_next   = {AW{1'b0}};
            fill_next  = {AW{1'b0}};
            state_next = (pre_cnt == {AW{1'b0}}) ? ARMED : PRE;
`ifdef CAPTURE_EDGE_TRIG_EN
            prev_valid_next = 1'b0;
`endif
        end else if (sample_ev) begin
            case (state)
                PRE: begin
                    write     = 1'b1;
                    fill_next = fill_inc;
                    if (fill_inc == pre_cnt) begin
                        state_next = ARMED;
                    end else begin
                        state_next = PRE;
                    end
                end
                ARMED: begin
                    write = 1'b1;
                    if (match) begin
                        trig_addr_next = ptr;
                        post_next      = {AW{1'b0}};
                        state_next     = (post_cnt == {AW{1'b0}}) ? DONE : POST;
                    end else begin
                        state_next = ARMED;
                    end
                end
                POST: begin
                    write     = 1'b1;
                    post_next = post_inc;
                    if (post_inc == post_cnt) begin
                        state_next = DONE;
                    end else begin
                        state_next = POST;
                    end
                end
                default: begin
                    write = 1'b0;
                end
            endcase
        end else begin
            state_next = state;
        end

        if (write) begin
            wr_addr_next = ptr;
            wr_data_next = sample_data;
            ptr_next     = ptr + AW'(1);
`ifdef CAPTURE_EDGE_TRIG_EN
            prev_next       = sample_data;
            prev_valid_next = 1'b1;
`endif
        end else begin
            wr_addr_next = wr_addr;
        end

        wr_en_next = write;
        busy_next  = (state_next == PRE) || (state_next == ARMED) || (state_next == POST);
        done_next  = (state_next == DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge rdclk) begin
        if (!nreset) begin
            state     <= IDLE;
            ptr       <= {AW{1'b0}};
            fill      <= {AW{1'b0}};
            post      <= {AW{1'b0}};
            trig_addr <= {AW{1'b0}};
            wr_en     <= 1'b0;
            wr_addr   <= {AW{1'b0}};
            wr_data   <= {WIDTH{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef CAPTURE_EDGE_TRIG_EN
            prev       <= {WIDTH{1'b0}};
            prev_valid <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            fill      <= fill_next;
            post      <= post_next;
            trig_addr <= trig_addr_next;
            wr_en     <= wr_en_next;
            wr_addr   <= wr_addr_next;
            wr_data   <= wr_data_next;
            busy      <= busy_next;
            done      <= done_next;
`ifdef CAPTURE_EDGE_TRIG_EN
            prev       <= prev_next;
            prev_valid <= prev_valid_next;
`endif
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed self-checking bench for capture_ctrl (WIDTH=8, AW=4).
module tb_capture_ctrl;

    logic       rdclk = 1'b0;
    logic       nreset;
    logic       start;
    logic       abort;
    logic       strobe;
    logic [7:0] din;
    logic [7:0] trig_mask;
    logic [7:0] trig_value;
`ifdef CAPTURE_EDGE_TRIG_EN
    logic [7:0] trig_edge;
`endif
    logic [3:0] pre_cnt;
    logic [3:0] post_cnt;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [3:0] trig_addr;

    int tests = 0;
    int fails = 0;

    always #5 rdclk = ~rdclk;

    capture_ctrl #(.WIDTH(8), .AW(4)) dut (
        .rdclk      (rdclk),
        .nreset     (nreset),
        .start      (start),
        .abort      (abort),
        .strobe     (strobe),
        .din        (din),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
`ifdef CAPTURE_EDGE_TRIG_EN
        .trig_edge  (trig_edge),
`endif
        .pre_cnt    (pre_cnt),
        .post_cnt   (post_cnt),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .trig_addr  (trig_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe pulse (3 high, 3 low); checks the write 3 cycles later and its single-cycle width.
    task automatic smp(input string tag, input logic [7:0] d, input logic exp_wr,
                       input logic [3:0] exp_addr, input logic exp_busy, input logic exp_done);
        din    = d;
        strobe = 1'b1;
        repeat (3) @(negedge rdclk);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(exp_wr));
        if (exp_wr) begin
            chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(exp_addr));
            chk({tag, ".wr_data"}, 32'(wr_data), 32'(d));
        end else begin
            chk({tag, ".no_write"}, 32'(wr_en), 32'(1'b0));
        end
        chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
        chk({tag, ".done"}, 32'(done), 32'(exp_done));
        strobe = 1'b0;
        @(negedge rdclk);
        chk({tag, ".pulse"}, 32'(wr_en), 32'(1'b0));
        repeat (2) @(negedge rdclk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge rdclk);
        start = 1'b0;
    endtask

    initial begin
        nreset = 1'b0; start = 1'b0; abort = 1'b0; strobe = 1'b0; din = 8'h00;
        trig_mask = 8'hFF; trig_value = 8'h00; pre_cnt = 4'd0; post_cnt = 4'd0;
`ifdef CAPTURE_EDGE_TRIG_EN
        trig_edge = 8'h00;
`endif
        @(negedge rdclk);

        // Reset held with the strobe toggling: nothing may move.
        for (int i = 0; i < 8; i++) begin
            strobe = i[1];
            din    = 8'(i * 17);
            @(negedge rdclk);
            chk("rst.wr_en", 32'(wr_en), 32'(1'b0));
            chk("rst.busy", 32'(busy), 32'(1'b0));
            chk("rst.done", 32'(done), 32'(1'b0));
        end
        chk("rst.wr_addr", 32'(wr_addr), 32'(4'd0));
        chk("rst.wr_data", 32'(wr_data), 32'(8'h00));
        chk("rst.trig_addr", 32'(trig_addr), 32'(4'd0));
        strobe = 1'b0;
        nreset = 1'b1;
        repeat (4) @(negedge rdclk);

        // Basic capture
        pre_cnt = 4'd3; post_cnt = 4'd2; trig_mask = 8'hFF; trig_value = 8'h5A;
        pulse_start();
        chk("basic.armed_busy", 32'(busy), 32'(1'b1));
        smp("basic0", 8'h01, 1'b1, 4'd0, 1'b1, 1'b0);
        smp("basic1", 8'h02, 1'b1, 4'd1, 1'b1, 1'b0);
        smp("basic2", 8'h03, 1'b1, 4'd2, 1'b1, 1'b0);
        smp("basic3", 8'h04, 1'b1, 4'd3, 1'b1, 1'b0);
        smp("basic4", 8'h5A, 1'b1, 4'd4, 1'b1, 1'b0);
        smp("basic5", 8'h06, 1'b1, 4'd5, 1'b1, 1'b0);
        smp("basic6", 8'h07, 1'b1, 4'd6, 1'b0, 1'b1);
        chk("basic.trig_addr", 32'(trig_addr), 32'(4'd4));
        smp("done_hold", 8'h5A, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("done_hold.trig_addr", 32'(trig_addr), 32'(4'd4));

        // Zero counts, re-armed from DONE
        pre_cnt = 4'd0; post_cnt = 4'd0; trig_mask = 8'h00; trig_value = 8'hFF;
        pulse_start();
        chk("zero.busy", 32'(busy), 32'(1'b1));
        chk("zero.done_cleared", 32'(done), 32'(1'b0));
        smp("zero0", 8'h33, 1'b1, 4'd0, 1'b0, 1'b1);
        chk("zero.trig_addr", 32'(trig_addr), 32'(4'd0));

        // Wrap-around: trigger on the 20th sample
        pre_cnt = 4'd2; post_cnt = 4'd3; trig_mask = 8'hFF; trig_value = 8'hC3;
        pulse_start();
        for (int i = 0; i < 19; i++) begin
            smp("wrap", 8'(i), 1'b1, 4'(i), 1'b1, 1'b0);
        end
        smp("wrap_trig", 8'hC3, 1'b1, 4'd3, 1'b1, 1'b0);
        smp("wrap_p0", 8'h40, 1'b1, 4'd4, 1'b1, 1'b0);
        smp("wrap_p1", 8'h41, 1'b1, 4'd5, 1'b1, 1'b0);
        smp("wrap_p2", 8'h42, 1'b1, 4'd6, 1'b0, 1'b1);
        chk("wrap.trig_addr", 32'(trig_addr), 32'(4'd3));

        // Control priority: start ignored while ARMED, abort in POST
        pre_cnt = 4'd0; post_cnt = 4'd3; trig_mask = 8'hFF; trig_value = 8'hAA;
        pulse_start();
        smp("ctl0", 8'h11, 1'b1, 4'd0, 1'b1, 1'b0);
        pulse_start();
        smp("ctl1", 8'h22, 1'b1, 4'd1, 1'b1, 1'b0);
        smp("ctl_trig", 8'hAA, 1'b1, 4'd2, 1'b1, 1'b0);
        smp("ctl_post", 8'h01, 1'b1, 4'd3, 1'b1, 1'b0);
        abort = 1'b1;
        @(negedge rdclk);
        abort = 1'b0;
        chk("abort.busy", 32'(busy), 32'(1'b0));
        chk("abort.done", 32'(done), 32'(1'b0));
        chk("abort.trig_addr", 32'(trig_addr), 32'(4'd2));
        smp("idle", 8'hAA, 1'b0, 4'd0, 1'b0, 1'b0);

        // Strobe already high at start: first sample is the next rising edge
        pre_cnt = 4'd0; post_cnt = 4'd0; trig_mask = 8'h00;
        strobe = 1'b1; din = 8'h77;
        repeat (4) @(negedge rdclk);
        pulse_start();
        repeat (3) @(negedge rdclk);
        chk("hi_at_start.wr_en", 32'(wr_en), 32'(1'b0));
        strobe = 1'b0;
        repeat (3) @(negedge rdclk);
        smp("hi_at_start", 8'h78, 1'b1, 4'd0, 1'b0, 1'b1);

`ifdef CAPTURE_EDGE_TRIG_EN
        // Edge trigger: bit0 sequence 1,1,0,1 matches only on the 4th sample
        pre_cnt = 4'd0; post_cnt = 4'd0; trig_mask = 8'h01; trig_value = 8'h01; trig_edge = 8'h01;
        pulse_start();
        smp("edge0", 8'h01, 1'b1, 4'd0, 1'b1, 1'b0);
        smp("edge1", 8'h01, 1'b1, 4'd1, 1'b1, 1'b0);
        smp("edge2", 8'h00, 1'b1, 4'd2, 1'b1, 1'b0);
        smp("edge3", 8'h01, 1'b1, 4'd3, 1'b0, 1'b1);
        chk("edge.trig_addr", 32'(trig_addr), 32'(4'd3));
`endif

        // Reset mid-capture abandons without a done
        pre_cnt = 4'd5; post_cnt = 4'd1; trig_mask = 8'hFF; trig_value = 8'h00;
        pulse_start();
        smp("mid", 8'h09, 1'b1, 4'd0, 1'b1, 1'b0);
        nreset = 1'b0;
        @(negedge rdclk);
        nreset = 1'b1;
        chk("midrst.busy", 32'(busy), 32'(1'b0));
        chk("midrst.done", 32'(done), 32'(1'b0));
        chk("midrst.trig_addr", 32'(trig_addr), 32'(4'd0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
